// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM encoding,
// default CPU-to-SRAM address base and external SRAM bus widths.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [31:0] DEFAULT_ADDR_BASE = 32'd1024;
  localparam int          SRAM_AW           = 18;
  localparam int          SRAM_DW           = 16;

endpackage

// File: rtl/sram_ctrl.sv
// MEM-stage responder that turns one 32-bit word access into two 16-bit
// accesses (low half, then high half) on an external asynchronous SRAM.
// ready is held low while a transaction is in flight so the pipeline freezes.
module sram_ctrl
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE     = DEFAULT_ADDR_BASE,
  parameter int          ACCESS_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic [SRAM_DW-1:0] sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_i
);

  localparam logic [2:0] LAST_CNT = 3'(ACCESS_CYCLES - 1);

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               is_wr_q, is_wr_d;
  logic [16:0]        word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] last_addr_q, last_addr_d;
  logic [31:0]        offset;
  logic               phase_last;
  logic               unused_offset_bits;

  // Byte offset from the SRAM base; wraps modulo 2^32, low two bits ignored.
  assign offset             = address - ADDR_BASE;
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
  assign phase_last         = (cnt_q == LAST_CNT);

  // Next-state logic: request latch, phase counting and read-data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_en || wr_en) begin
          state_d = ST_LOW;
          cnt_d   = 3'd0;
          is_wr_d = wr_en;          // write wins if both are requested
          word_d  = offset[18:2];
          wdata_d = wdata;
        end
      end
      ST_LOW: begin
        if (phase_last) begin
          state_d = ST_HIGH;
          cnt_d   = 3'd0;
          if (!is_wr_q) rdata_d[15:0] = sram_dq_i;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_HIGH: begin
        if (phase_last) begin
          state_d = ST_DONE;
          cnt_d   = 3'd0;
          if (!is_wr_q) rdata_d[31:16] = sram_dq_i;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // SRAM pin drive and pipeline handshake, decoded straight from the state so
  // an asynchronous reset releases the bus immediately.
  always_comb begin
    ready      = 1'b0;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    sram_dq_o  = '0;
    sram_addr  = last_addr_q;
    unique case (state_q)
      ST_IDLE: ready = ~rd_en & ~wr_en;
      ST_LOW: begin
        sram_addr  = {word_q, 1'b0};
        sram_we_n  = ~is_wr_q;
        sram_dq_oe = is_wr_q;
        sram_dq_o  = is_wr_q ? wdata_q[15:0] : '0;
      end
      ST_HIGH: begin
        sram_addr  = {word_q, 1'b1};
        sram_we_n  = ~is_wr_q;
        sram_dq_oe = is_wr_q;
        sram_dq_o  = is_wr_q ? wdata_q[31:16] : '0;
      end
      ST_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign last_addr_d = sram_addr;
  assign rdata       = rdata_q;

  // Control state, read data and held SRAM address with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      is_wr_q     <= 1'b0;
      rdata_q     <= '0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      rdata_q     <= rdata_d;
      last_addr_q <= last_addr_d;
    end
  end

  // Latched request payload; only meaningful inside LOW/HIGH, so no reset.
  always_ff @(posedge clk) begin
    word_q  <= word_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl with a behavioural SRAM and a
// transaction-timeline reference model.
module tb_sram_ctrl;
  import arm_mem_pkg::*;

  localparam int          A    = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk, rst, rd_en, wr_en;
  logic [31:0] address, wdata, rdata;
  logic        ready, sram_we_n, sram_dq_oe;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 0;
  bit mem_clear = 1;

  sram_ctrl #(.ADDR_BASE(BASE), .ACCESS_CYCLES(A)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
    .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // sram_model: 256K x 16, combinational read, write when we_n low at the edge
  logic [15:0] sram_mem [0:262143];
  assign sram_dq_i = sram_mem[sram_addr];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 262144; i++) sram_mem[i] <= 16'h0;
    end else if (!sram_we_n) begin
      sram_mem[sram_addr] <= sram_dq_o;
    end
  end

  // Reference: a transaction is numbered by cycles since its request was seen
  logic        m_active;
  int          m_c;
  logic        m_wr;
  logic [16:0] m_word;
  logic [31:0] m_wd, m_rdata, m_off;
  logic [17:0] m_last;
  assign m_off = address - BASE;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 0; m_c <= 0; m_rdata <= 0; m_last <= 0;
    end else if (!m_active) begin
      if (rd_en || wr_en) begin
        m_active <= 1; m_c <= 1; m_wr <= wr_en;
        m_word <= m_off[18:2]; m_wd <= wdata;
      end
    end else begin
      if (m_c <= 2*A) m_last <= {m_word, 1'(m_c > A)};
      if (!m_wr && m_c == A)   m_rdata[15:0]  <= sram_mem[{m_word, 1'b0}];
      if (!m_wr && m_c == 2*A) m_rdata[31:16] <= sram_mem[{m_word, 1'b1}];
      if (m_c == 2*A+1) m_active <= 0;
      else m_c <= m_c + 1;
    end
  end

  logic        e_ready, e_we_n, e_oe;
  logic [17:0] e_addr;
  logic [15:0] e_dq;
  always_comb begin
    e_ready = !(rd_en || wr_en);
    e_we_n  = 1; e_oe = 0; e_addr = m_last; e_dq = 16'h0;
    if (m_active && m_c <= 2*A) begin
      e_ready = 0;
      e_we_n  = !m_wr;
      e_oe    = m_wr;
      e_addr  = {m_word, 1'(m_c > A)};
      e_dq    = (m_c > A) ? m_wd[31:16] : m_wd[15:0];
    end else if (m_active) begin
      e_ready = 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("ready", 32'(ready), 32'(e_ready));
      chk("sram_we_n", 32'(sram_we_n), 32'(e_we_n));
      chk("sram_dq_oe", 32'(sram_dq_oe), 32'(e_oe));
      chk("sram_addr", 32'(sram_addr), 32'(e_addr));
      chk("rdata", rdata, m_rdata);
      if (e_oe) chk("sram_dq_o", 32'(sram_dq_o), 32'(e_dq));
    end
  end

  // Word-level golden memory for end-to-end read-back
  logic [31:0] golden [int unsigned];

  function automatic int unsigned word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return 32'(off[18:2]);
  endfunction

  task automatic txn(input bit wr, input bit both, input logic [31:0] a,
                     input logic [31:0] d, input string tag, output logic [31:0] got);
    int lows; bit seen; logic [31:0] g;
    rd_en = !wr || both; wr_en = wr; address = a; wdata = d;
    lows = 0; seen = 0; got = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ready) seen = 1; else lows++;
    end
    chk({tag, " completed"}, 32'(seen), 32'd1);
    chk({tag, " ready-low cycles"}, lows, 2*A+1);
    if (wr) golden[word_of(a)] = d;
    else begin
      got = rdata;
      g = golden.exists(word_of(a)) ? golden[word_of(a)] : 32'h0;
      chk({tag, " read value"}, got, g);
    end
    @(posedge clk); #1;
    rd_en = 0; wr_en = 0;
  endtask

  initial begin
    logic [31:0] got;
    int lows; bit seen;
    rst = 1; rd_en = 0; wr_en = 0; address = 0; wdata = 0;
    @(posedge clk); #1 mem_clear = 0;
    cmp_on = 1;
    @(negedge clk);
    chk("reset ready", 32'(ready), 1);
    chk("reset we_n", 32'(sram_we_n), 1);
    chk("reset oe", 32'(sram_dq_oe), 0);
    chk("reset addr", 32'(sram_addr), 0);
    chk("reset rdata", rdata, 0);
    chk("reset dq_o", 32'(sram_dq_o), 0);
    @(posedge clk); #1 rst = 0;

    // Idle
    repeat (20) @(posedge clk);
    #1;

    // Write then read back
    txn(1, 0, 32'd1032, 32'hDEADBEEF, "wr1032", got);
    chk("mem[4]", 32'(sram_mem[4]), 32'h0000BEEF);
    chk("mem[5]", 32'(sram_mem[5]), 32'h0000DEAD);
    txn(0, 0, 32'd1032, 32'h0, "rd1032", got);
    chk("rd1032 literal", got, 32'hDEADBEEF);

    // Back-to-back, then base address
    txn(1, 0, 32'd1036, 32'h12345678, "b2b wr", got);
    txn(0, 0, 32'd1036, 32'h0, "b2b rd", got);
    chk("b2b rd literal", got, 32'h12345678);
    txn(1, 0, 32'd1024, 32'h0BAD0CAB, "wr1024", got);
    chk("mem[0]", 32'(sram_mem[0]), 32'h00000CAB);
    chk("mem[1]", 32'(sram_mem[1]), 32'h00000BAD);

    // Request dropped mid-read
    rd_en = 1; address = 32'd1032;
    @(negedge clk); chk("drop ready c0", 32'(ready), 0);
    @(posedge clk); #1;
    @(posedge clk); #1 rd_en = 0; address = 32'h0;
    lows = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ready) seen = 1; else lows++;
    end
    chk("drop completed", 32'(seen), 1);
    chk("drop ready-low from c2", lows, 3);
    chk("drop rdata", rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    @(negedge clk); chk("drop back idle", 32'(ready), 1);
    @(posedge clk); #1;

    // Reset mid-write
    txn(1, 0, 32'd1040, 32'hAAAA5555, "pre1040", got);
    wr_en = 1; address = 32'd1040; wdata = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #2 rst = 1; wr_en = 0;
    #1;
    chk("rst we_n", 32'(sram_we_n), 1);
    chk("rst oe", 32'(sram_dq_oe), 0);
    chk("rst rdata", rdata, 0);
    @(posedge clk); #1 rst = 0;
    golden[word_of(32'd1040)] = 32'hAAAAF00D;
    txn(0, 0, 32'd1040, 32'h0, "rd1040", got);
    chk("rd1040 literal", got, 32'hAAAAF00D);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      bit wr, both; logic [31:0] a;
      wr   = 1'($urandom_range(0, 1));
      both = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) != 0) a = BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      else a = $urandom();
      txn(wr, both, a, $urandom(), "rand", got);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1 cmp_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
